// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding unit.
//   REG_ADDR_W : architectural register address width
//   X0         : hard-wired zero register address
//   sb_entry_t : scoreboard entry {valid, rd, is_load}
//   rs_match   : entry-versus-source-operand match helper
package pipe_hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(0);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

    // A scoreboard entry produces a source operand when it writes that
    // register, the register is not x0 and the operand is actually read.
    function automatic logic rs_match(
        input sb_entry_t             entry,
        input logic [REG_ADDR_W-1:0] rs_addr,
        input logic                  rs_used
    );
        return entry.valid && (entry.rd == rs_addr) && (rs_addr != X0) && rs_used;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Per-operand forwarding selector: finds the youngest in-flight writer of
// the source register and returns the resolved operand plus a hazard flag.
// Optional feature macro: HAZ_PERF_CNT_EN (adds the fwd_c flag).
// Ports:
//   sb         : scoreboard, index 0 = stage directly after issue
//   rs_addr    : source register address
//   rs_used    : operand is actually read
//   rf_data    : register-file read data
//   stage_data : per-stage result bus, slice k = stage k
//   value_c    : resolved operand (combinational)
//   hazard_c   : youngest writer's data is not yet available
//   fwd_c      : operand taken from stage_data (HAZ_PERF_CNT_EN only)
module pipe_fwd_select
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  sb_entry_t [STAGES-1:0]      sb,
    input  logic [REG_ADDR_W-1:0]       rs_addr,
    input  logic                        rs_used,
    input  logic [XLEN-1:0]             rf_data,
    input  logic [STAGES*XLEN-1:0]      stage_data,
    output logic [XLEN-1:0]             value_c,
    output logic                        hazard_c
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic                        fwd_c
`endif
);

    logic            hit_c;
    logic            ready_c;
    logic [XLEN-1:0] hit_data_c;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit_c      = 1'b0;
        ready_c    = 1'b0;
        hit_data_c = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (rs_match(sb[k], rs_addr, rs_used)) begin
                hit_c      = 1'b1;
                ready_c    = !sb[k].is_load || (k >= int'(LOAD_LAT));
                hit_data_c = stage_data[k*XLEN +: XLEN];
            end
        end
    end

    // Operand mux: x0 is always zero, a ready match forwards, else register file.
    always_comb begin
        value_c = rf_data;
        if (rs_addr == X0) begin
            value_c = '0;
        end else if (hit_c && ready_c) begin
            value_c = hit_data_c;
        end
    end

    assign hazard_c = hit_c && !ready_c;

`ifdef HAZ_PERF_CNT_EN
    assign fwd_c = hit_c && ready_c;
`endif

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding unit for the pipelined RV32I core. Tracks in-flight
// register writes in a shifting scoreboard (one entry per post-issue stage),
// resolves rs1/rs2 for the issue stage, raises load-use stalls and flushes
// on branch redirect.
// Optional feature macro: HAZ_PERF_CNT_EN (stall / forward event counters).
// Ports:
//   clk_i, rst_n_i                 : clock, async active-low reset
//   is_*_i                         : issue-stage instruction fields
//   rf_rs1_data_i, rf_rs2_data_i   : register-file read data
//   stage_data_i                   : result bus, slice k = stage k
//   redirect_i                     : taken branch/jump resolved in stage 0
//   rs1_val_o, rs2_val_o           : resolved operands (combinational)
//   stall_o                        : hold PC and IF/IS registers (combinational)
//   flush_o                        : squash IF and issue (combinational)
//   stall_cnt_o, fwd_cnt_o         : event counters (HAZ_PERF_CNT_EN only)
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    is_valid_i,
    input  logic [REG_ADDR_W-1:0]   is_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]   is_rs2_addr_i,
    input  logic                    is_rs1_used_i,
    input  logic                    is_rs2_used_i,
    input  logic [REG_ADDR_W-1:0]   is_rd_addr_i,
    input  logic                    is_reg_write_i,
    input  logic                    is_load_i,
    input  logic [XLEN-1:0]         rf_rs1_data_i,
    input  logic [XLEN-1:0]         rf_rs2_data_i,
    input  logic [STAGES*XLEN-1:0]  stage_data_i,
    input  logic                    redirect_i,
    output logic [XLEN-1:0]         rs1_val_o,
    output logic [XLEN-1:0]         rs2_val_o,
    output logic                    stall_o,
    output logic                    flush_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             fwd_cnt_o
`endif
);

    sb_entry_t [STAGES-1:0] sb_q;
    sb_entry_t              entry0_c;
    logic                   rs1_hazard_c;
    logic                   rs2_hazard_c;

`ifdef HAZ_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic             rs1_fwd_c;
    logic             rs2_fwd_c;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;
`endif

    pipe_fwd_select #(
        .XLEN     (XLEN),
        .STAGES   (STAGES),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rs1 (
        .sb         (sb_q),
        .rs_addr    (is_rs1_addr_i),
        .rs_used    (is_rs1_used_i),
        .rf_data    (rf_rs1_data_i),
        .stage_data (stage_data_i),
        .value_c    (rs1_val_o),
        .hazard_c   (rs1_hazard_c)
`ifdef HAZ_PERF_CNT_EN
        ,
        .fwd_c      (rs1_fwd_c)
`endif
    );

    pipe_fwd_select #(
        .XLEN     (XLEN),
        .STAGES   (STAGES),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rs2 (
        .sb         (sb_q),
        .rs_addr    (is_rs2_addr_i),
        .rs_used    (is_rs2_used_i),
        .rf_data    (rf_rs2_data_i),
        .stage_data (stage_data_i),
        .value_c    (rs2_val_o),
        .hazard_c   (rs2_hazard_c)
`ifdef HAZ_PERF_CNT_EN
        ,
        .fwd_c      (rs2_fwd_c)
`endif
    );

    // Redirect takes precedence: a squashed instruction must not also stall.
    assign stall_o = is_valid_i && !redirect_i && (rs1_hazard_c || rs2_hazard_c);
    assign flush_o = redirect_i;

    // New stage-0 entry: the issuing instruction, or a bubble when it is
    // absent, held back by a stall, or squashed by a redirect.
    always_comb begin
        entry0_c = '0;
        if (is_valid_i && !stall_o && !redirect_i) begin
            entry0_c.valid   = is_reg_write_i && (is_rd_addr_i != X0);
            entry0_c.rd      = is_rd_addr_i;
            entry0_c.is_load = is_load_i;
        end
    end

    // Scoreboard shifts every cycle; downstream stages never stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_q <= '0;
        end else begin
            sb_q[0] <= entry0_c;
            for (int k = 1; k < int'(STAGES); k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Stall cycles and cycles where a valid issue operand came from stage_data_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (is_valid_i && (rs1_fwd_c || rs2_fwd_c)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: instance A uses the default
// configuration (STAGES=2, LOAD_LAT=1), instance B uses STAGES=4, LOAD_LAT=2.
module tb_pipe_hazard_unit;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_a, valid_b;
    logic [4:0]        rs1, rs2, rd;
    logic              u1, u2, wr, ld;
    logic [XLEN-1:0]   rf1, rf2;
    logic [2*XLEN-1:0] sd_a;
    logic [4*XLEN-1:0] sd_b;
    logic              redirect;

    logic [XLEN-1:0]   rs1_a, rs2_a, rs1_b, rs2_b;
    logic              stall_a, flush_a, stall_b, flush_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       stall_cnt_a, fwd_cnt_a, stall_cnt_b, fwd_cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.XLEN(XLEN), .STAGES(2), .LOAD_LAT(1)) dut_a (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .is_valid_i     (valid_a),
        .is_rs1_addr_i  (rs1),
        .is_rs2_addr_i  (rs2),
        .is_rs1_used_i  (u1),
        .is_rs2_used_i  (u2),
        .is_rd_addr_i   (rd),
        .is_reg_write_i (wr),
        .is_load_i      (ld),
        .rf_rs1_data_i  (rf1),
        .rf_rs2_data_i  (rf2),
        .stage_data_i   (sd_a),
        .redirect_i     (redirect),
        .rs1_val_o      (rs1_a),
        .rs2_val_o      (rs2_a),
        .stall_o        (stall_a),
        .flush_o        (flush_a)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_a),
        .fwd_cnt_o      (fwd_cnt_a)
`endif
    );

    pipe_hazard_unit #(.XLEN(XLEN), .STAGES(4), .LOAD_LAT(2)) dut_b (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .is_valid_i     (valid_b),
        .is_rs1_addr_i  (rs1),
        .is_rs2_addr_i  (rs2),
        .is_rs1_used_i  (u1),
        .is_rs2_used_i  (u2),
        .is_rd_addr_i   (rd),
        .is_reg_write_i (wr),
        .is_load_i      (ld),
        .rf_rs1_data_i  (rf1),
        .rf_rs2_data_i  (rf2),
        .stage_data_i   (sd_b),
        .redirect_i     (redirect),
        .rs1_val_o      (rs1_b),
        .rs2_val_o      (rs2_b),
        .stall_o        (stall_b),
        .flush_o        (flush_b)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_b),
        .fwd_cnt_o      (fwd_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [4:0] a1, input logic us1, input logic [4:0] a2,
                         input logic us2, input logic [4:0] dst, input logic w, input logic l);
        valid_a = 1'b1;
        rs1 = a1; u1 = us1; rs2 = a2; u2 = us2; rd = dst; wr = w; ld = l;
    endtask

    task automatic idle();
        valid_a = 1'b0; valid_b = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
        rd = 5'd0; wr = 1'b0; ld = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0; redirect = 1'b0;
        rf1 = '0; rf2 = '0; sd_a = '0; sd_b = '0;

        // Reset state
        #2;
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_flush_a", 32'(flush_a), 32'd0);
        check("rst_stall_b", 32'(stall_b), 32'd0);
        redirect = 1'b1;
        settle();
        check("rst_flush_follow", 32'(flush_a), 32'd1);
        redirect = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU dependency: addi x5,x0,7 ; add x6,x5,x5
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        rf1 = 32'h111; rf2 = 32'h222;
        settle();
        check("alu_x0_src", rs1_a, 32'd0);
        check("alu_first_stall", 32'(stall_a), 32'd0);
        tick();
        issue(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        rf1 = 32'h55; rf2 = 32'h66; sd_a = {32'hAAAA, 32'd7};
        settle();
        check("alu_fwd_rs1", rs1_a, 32'd7);
        check("alu_fwd_rs2", rs2_a, 32'd7);
        check("alu_stall", 32'(stall_a), 32'd0);
        tick(); idle(); tick(); tick();

        // Load-use: lw x5,0(x2) ; add x6,x5,x1
        issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        rf1 = 32'h22; sd_a = '0;
        settle();
        check("lu_lw_rf", rs1_a, 32'h22);
        check("lu_lw_stall", 32'(stall_a), 32'd0);
        tick();
        issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        rf1 = 32'h5555; rf2 = 32'h0101; sd_a = {32'h0, 32'h1234};
        settle();
        check("lu_stall_c1", 32'(stall_a), 32'd1);
        check("lu_rs2_rf", rs2_a, 32'h0101);
        tick();
        sd_a = {32'hDEADBEEF, 32'h0};
        settle();
        check("lu_stall_c2", 32'(stall_a), 32'd0);
        check("lu_fwd_load", rs1_a, 32'hDEADBEEF);
        check("lu_rs2_rf2", rs2_a, 32'h0101);
        tick(); idle(); tick(); tick();

        // Dual match: x5 at stage 0 (3) and stage 1 (9); youngest wins
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd5, 1'b1, 5'd5, 1'b0, 5'd9, 1'b1, 1'b0);
        rf1 = 32'h51; rf2 = 32'h52; sd_a = {32'd9, 32'd3};
        settle();
        check("dual_youngest", rs1_a, 32'd3);
        check("dual_unused_rf", rs2_a, 32'h52);
        check("dual_stall", 32'(stall_a), 32'd0);
        u2 = 1'b1;
        settle();
        check("dual_rs2_used", rs2_a, 32'd3);
        tick(); idle(); tick(); tick();

        // x0 destination: addi x0,x0,5 ; consumer of x0
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
        rf1 = 32'hFFFF; rf2 = 32'hEEEE; sd_a = {32'h0, 32'd5};
        settle();
        check("x0_rs1", rs1_a, 32'd0);
        check("x0_rs2", rs2_a, 32'd0);
        check("x0_stall", 32'(stall_a), 32'd0);
        tick(); idle(); tick(); tick();

        // Redirect during a load-use hazard: squashed consumer writes x8
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        sd_a = '0;
        tick();
        issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        redirect = 1'b1;
        settle();
        check("redir_flush", 32'(flush_a), 32'd1);
        check("redir_stall", 32'(stall_a), 32'd0);
        tick();
        redirect = 1'b0;
        issue(5'd8, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        rf1 = 32'h88; rf2 = 32'h99; sd_a = {32'h77, 32'hBAD};
        settle();
        check("redir_bubble", rs1_a, 32'h88);
        check("redir_load_fwd", rs2_a, 32'h77);
        check("redir_after_stall", 32'(stall_a), 32'd0);
        check("redir_after_flush", 32'(flush_a), 32'd0);
        tick(); idle(); tick(); tick();

        // Asynchronous reset while stalled clears the hazard immediately
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        settle();
        check("rstmid_pre", 32'(stall_a), 32'd1);
        rst_n = 1'b0;
        settle();
        check("rstmid_post", 32'(stall_a), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // STAGES=4, LOAD_LAT=2: lw x7 then use -> two stall cycles
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        valid_a = 1'b0; valid_b = 1'b1;
        sd_b = '0;
        settle();
        check("b_lw_stall", 32'(stall_b), 32'd0);
        tick();
        issue(5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
        valid_a = 1'b0; valid_b = 1'b1;
        rf1 = 32'h70; rf2 = 32'h33;
        settle();
        check("b_stall_c1", 32'(stall_b), 32'd1);
        tick();
        settle();
        check("b_stall_c2", 32'(stall_b), 32'd1);
        check("b_rs2_rf", rs2_b, 32'h33);
        tick();
        sd_b[95:64] = 32'hCAFE0007;
        settle();
        check("b_stall_c3", 32'(stall_b), 32'd0);
        check("b_fwd_stage2", rs1_b, 32'hCAFE0007);
        tick();
        idle();
        settle();
`ifdef HAZ_PERF_CNT_EN
        check("b_stall_cnt", stall_cnt_b, 32'd2);
        check("b_fwd_cnt", fwd_cnt_b, 32'd1);
`endif
        check("b_idle_stall", 32'(stall_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
